wb_trace_buffer: RTL and testbench

//   Passive consumer of the datapath writeback-stage signals. Captures every retired

---
 rtl/wb_trace_buffer.sv | 141 ++++++++++++++
 tb/tb_wb_trace_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - writeback-stage trace FIFO of {cycle, dest, data} records; optional TRACE_WDOG_EN idle watchdog
module wb_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wwreg,
  input  logic                       wm2reg,
  input  logic [4:0]                 wdestReg,
  input  logic [31:0]                wr,
  input  logic [31:0]                wdo,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [4:0]                 rd_dest,
  output logic [31:0]                rd_data,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
`ifdef TRACE_WDOG_EN
  ,
  output logic                       hang
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Elaboration-time guard on the configuration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_LIMIT < 1) begin : g_bad_cfg
    $error("wb_trace_buffer: DEPTH must be a power of 2 >= 2 and WDOG_LIMIT >= 1");
  end

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;

  logic [4:0]        dest_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [CYC_W-1:0]  cyc_mem  [DEPTH];

  logic              empty;
  logic              full;
  logic              capture;
  logic              pop;
  logic              push;
  logic [31:0]       cap_data;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign capture  = wwreg && (wdestReg != 5'd0);
  assign cap_data = wm2reg ? wdo : wr;
  // clr swallows any pop or push sampled at the same edge
  assign pop      = !clr && !empty && rd_ready;
  // a full FIFO still accepts a record when the head leaves at the same edge
  assign push     = !clr && capture && (!full || pop);

  // Next-state for pointers, timestamp and drop accounting
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cycle_d    = cycle_q + 1'b1;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cycle_d    = '0;
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (capture && !push) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Record storage; contents are only visible through the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_q[AW-1:0]] <= wdestReg;
      data_mem[wr_ptr_q[AW-1:0]] <= cap_data;
      cyc_mem[wr_ptr_q[AW-1:0]]  <= cycle_q;
    end
  end

  assign rd_valid = !empty;
  assign rd_dest  = empty ? 5'd0 : dest_mem[rd_ptr_q[AW-1:0]];
  assign rd_data  = empty ? 32'd0 : data_mem[rd_ptr_q[AW-1:0]];
  assign rd_cycle = empty ? '0 : cyc_mem[rd_ptr_q[AW-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

`ifdef TRACE_WDOG_EN
  localparam int IW = $clog2(WDOG_LIMIT) + 1;
  localparam logic [IW-1:0] WD_MAX = IW'(WDOG_LIMIT);

  logic [IW-1:0] idle_q, idle_d;

  // Idle counter: cleared by any capture attempt or clr, saturates at the limit
  always_comb begin
    idle_d = idle_q;
    if (clr || capture)      idle_d = '0;
    else if (idle_q != WD_MAX) idle_d = idle_q + 1'b1;
  end

  // Idle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  assign hang = (idle_q == WD_MAX);
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - randomized self-checking bench for wb_trace_buffer against a queue model
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, clr, wwreg, wm2reg, rd_ready;
  logic [4:0]  wdestReg;
  logic [31:0] wr, wdo;
  logic        rd_valid, overflow;
  logic [4:0]  rd_dest;
  logic [31:0] rd_data;
  logic [15:0] rd_cycle;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;
`ifdef TRACE_WDOG_EN
  logic        hang;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_trace_buffer #(.DEPTH(16), .CYC_W(16), .WDOG_LIMIT(64)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wwreg(wwreg), .wm2reg(wm2reg),
    .wdestReg(wdestReg), .wr(wr), .wdo(wdo), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_dest(rd_dest), .rd_data(rd_data),
    .rd_cycle(rd_cycle), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef TRACE_WDOG_EN
    , .hang(hang)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [15:0] cyc;
  } rec_t;

  rec_t        mq[$];
  logic [15:0] m_cyc;
  bit          m_ovf;
  int          m_drop;
  int          m_idle;

  task automatic model_reset();
    mq.delete();
    m_cyc = 0; m_ovf = 0; m_drop = 0; m_idle = 0;
  endtask

  // Apply the effect of the coming rising edge using the inputs as they stand now
  task automatic model_edge();
    rec_t r;
    bit cap;
    if (rst) begin
      model_reset();
    end else if (clr) begin
      model_reset();
    end else begin
      cap = wwreg && (wdestReg != 0);
      if (mq.size() > 0 && rd_ready) mq.delete(0);
      if (cap) begin
        if (mq.size() < 16) begin
          r.dest = wdestReg; r.data = wm2reg ? wdo : wr; r.cyc = m_cyc;
          mq.push_back(r);
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_cyc  = m_cyc + 16'd1;
      m_idle = cap ? 0 : (m_idle < 64 ? m_idle + 1 : 64);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input bit m2, input logic [4:0] d,
                       input logic [31:0] r, input logic [31:0] o,
                       input bit rdy, input bit c);
    wwreg = w; wm2reg = m2; wdestReg = d; wr = r; wdo = o; rd_ready = rdy; clr = c;
  endtask

  task automatic idle_in();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic do_clr();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 1);
    tick();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    drive(1, 0, 5'd4, 32'h11, 32'h0, 0, 0); tick();
    drive(1, 0, 5'd5, 32'h22, 32'h0, 0, 0); tick();
    idle_in();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%0b count=%0d ovf=%0b drop=%0d, expected 0 0 0 0",
               rd_valid, count, overflow, drop_cnt);
    end
    n_checks++;
    if (rd_data !== 32'd0 || rd_dest !== 5'd0 || rd_cycle !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dest=%0d data=%0h cyc=%0d, expected 0", rd_dest, rd_data, rd_cycle);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_capture_select();
    idle_in();
    tick(); tick(); tick();
    drive(1, 0, 5'd8, 32'h0000_0005, 32'h1234_5678, 0, 0);
    tick();
    drive(1, 1, 5'd9, 32'h0000_0077, 32'hDEAD_BEEF, 0, 0);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_dest !== 5'd8 || rd_data !== 32'd5 || rd_cycle !== 16'd3) begin
      n_fail++;
      $display("FAIL capture_alu: got v=%0b dest=%0d data=%0h cyc=%0d, expected 1 8 5 3",
               rd_valid, rd_dest, rd_data, rd_cycle);
    end
    tick();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 1, 0);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_dest !== 5'd9 || rd_data !== 32'hDEAD_BEEF || rd_cycle !== 16'd4) begin
      n_fail++;
      $display("FAIL capture_load: got v=%0b dest=%0d data=%0h cyc=%0d, expected 1 9 deadbeef 4",
               rd_valid, rd_dest, rd_data, rd_cycle);
    end
    tick();
    idle_in();
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL capture_drained: got v=%0b count=%0d, expected 0 0", rd_valid, count);
    end
  endtask

  task automatic test_filter();
    drive(1, 0, 5'd0, $urandom, $urandom, 0, 0); tick();
    drive(0, 0, 5'd5, $urandom, $urandom, 0, 0); tick();
    idle_in();
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL filter: got v=%0b count=%0d, expected 0 0", rd_valid, count);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, 5'((i % 31) + 1), 32'(i + 1), $urandom, 0, 0);
      tick();
    end
    idle_in();
    n_checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overflow_state: got count=%0d ovf=%0b drop=%0d, expected 16 1 2", count, overflow, drop_cnt);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL overflow_drain[%0d]: got v=%0b data=%0d, expected 1 %0d", i, rd_valid, rd_data, i + 1);
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL overflow_empty: got v=%0b count=%0d, expected 0 0", rd_valid, count);
    end
  endtask

  task automatic test_full_push_pop();
    do_clr();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 5'd3, 32'(100 + i), 32'd0, 0, 0);
      tick();
    end
    drive(1, 0, 5'd3, 32'd200, 32'd0, 1, 0);
    tick();
    idle_in();
    n_checks++;
    if (count !== 5'd16 || rd_data !== 32'd101 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got count=%0d head=%0d ovf=%0b, expected 16 101 0", count, rd_data, overflow);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_data !== ((i == 15) ? 32'd200 : 32'(101 + i))) begin
        n_fail++;
        $display("FAIL full_push_pop_drain[%0d]: got %0d, expected %0d", i, rd_data,
                 (i == 15) ? 200 : 101 + i);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_clr();
    for (int i = 0; i < 16 + 260; i++) begin
      drive(1, 0, 5'd7, $urandom, $urandom, 0, 0);
      tick();
    end
    idle_in();
    n_checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL drop_saturate: got drop=%0d ovf=%0b count=%0d, expected 255 1 16", drop_cnt, overflow, count);
    end
    drive(1, 0, 5'd7, 32'h5, 32'h0, 1, 1);
    tick();
    idle_in();
    n_checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0 || count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got drop=%0d ovf=%0b count=%0d v=%0b data=%0h, expected 0 0 0 0 0",
               drop_cnt, overflow, count, rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_data;
    logic [4:0]  e_dest;
    logic [15:0] e_cyc;
    do_clr();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 10) < 7, $urandom % 2, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, ($urandom % 100) < ((i / 150) % 2 == 0 ? 30 : 70),
            ($urandom % 60) == 0);
      tick();
      e_dest = mq.size() > 0 ? mq[0].dest : 5'd0;
      e_data = mq.size() > 0 ? mq[0].data : 32'd0;
      e_cyc  = mq.size() > 0 ? mq[0].cyc  : 16'd0;
      n_checks++;
      if (rd_valid !== (mq.size() > 0) || count !== 5'(mq.size()) || rd_dest !== e_dest ||
          rd_data !== e_data || rd_cycle !== e_cyc) begin
        n_fail++;
        $display("FAIL random_head[%0d]: got v=%0b n=%0d dest=%0d data=%0h cyc=%0d, expected %0b %0d %0d %0h %0d",
                 i, rd_valid, count, rd_dest, rd_data, rd_cycle, mq.size() > 0, mq.size(), e_dest, e_data, e_cyc);
      end
      n_checks++;
      if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL random_drop[%0d]: got ovf=%0b drop=%0d, expected %0b %0d", i, overflow, drop_cnt, m_ovf, m_drop);
      end
`ifdef TRACE_WDOG_EN
      n_checks++;
      if (hang !== (m_idle == 64)) begin
        n_fail++;
        $display("FAIL random_hang[%0d]: got %0b, expected %0b", i, hang, m_idle == 64);
      end
`endif
    end
    idle_in();
  endtask

`ifdef TRACE_WDOG_EN
  task automatic test_watchdog();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5'd2, $urandom, 32'd0, 0, 0);
      tick();
    end
    do_clr();
    n_checks++;
    if (count !== 5'd0 || drop_cnt !== 8'd0 || hang !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_clr: got count=%0d drop=%0d hang=%0b, expected 0 0 0", count, drop_cnt, hang);
    end
    for (int i = 0; i < 63; i++) tick();
    n_checks++;
    if (hang !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_63: got hang=%0b, expected 0", hang);
    end
    tick();
    n_checks++;
    if (hang !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_64: got hang=%0b, expected 1", hang);
    end
    drive(1, 0, 5'd6, 32'h1, 32'h0, 0, 0);
    tick();
    idle_in();
    n_checks++;
    if (hang !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_capture: got hang=%0b, expected 0", hang);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_in();
    model_reset();
    test_reset();
    test_capture_select();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_random();
`ifdef TRACE_WDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
